// File: rtl/regfile_mp.sv
// regfile_mp: two-write, three-read register file with bypass, collision flag and load scoreboard.
// Latency: writes land at the next CLK edge; reads and BUSY are combinational (same-cycle forwarding when BYPASS=1).
// Backpressure: none; every write is accepted, BUSY1/BUSY2 feed the hazard unit's stall decision.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A4,
  output logic [DATA_W-1:0] RD4,
  input  logic [DATA_W-1:0] R15,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              WE5,
  input  logic [ADDR_W-1:0] A5,
  input  logic [DATA_W-1:0] WD5,
  input  logic              MARK,
  input  logic [ADDR_W-1:0] AM,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic              WERR
);

  // The PC slot has no storage: it is the last architectural index and is
  // sourced from R15, so only PC_IDX words (0..PC_IDX-1) are kept.
  localparam int              NREG = PC_IDX;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] r_mem [NREG];
  logic [NREG-1:0]   r_pend;
  logic              r_werr;

  logic w_byp;
  logic w_wr3;
  logic w_wr5;
  logic w_coll;
  logic w_mark;

  logic [DATA_W-1:0] w_st1;
  logic [DATA_W-1:0] w_st2;

  assign w_byp = (BYPASS != 0);

  // Write qualification: PC writes are dropped, and on an address collision
  // the primary port wins while the secondary port is suppressed.
  assign w_wr3  = WE3 && (A3 != PC_A);
  assign w_coll = w_wr3 && WE5 && (A3 == A5);
  assign w_wr5  = WE5 && (A5 != PC_A) && !w_coll;
  assign w_mark = MARK && (AM != PC_A);

  // Register storage update; reset clears every word and blocks all writes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr3) r_mem[A3] <= WD3;
      if (w_wr5) r_mem[A5] <= WD5;
    end
  end

  // Pending-load scoreboard: WE3 retires a load, MARK issues one; a MARK to
  // the same index in the same cycle is applied last so the new load wins.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pend <= '0;
    end else begin
      if (w_wr3)  r_pend[A3] <= 1'b0;
      if (w_mark) r_pend[AM] <= 1'b1;
    end
  end

  // Collision flag: one-cycle registered pulse following a same-address dual write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_werr <= 1'b0;
    end else begin
      r_werr <= w_coll;
    end
  end

  assign WERR = r_werr;

  // Stored-value lookup for the operand ports; the PC index never touches storage.
  always_comb begin
    w_st1 = '0;
    w_st2 = '0;
    if (A1 != PC_A) w_st1 = r_mem[A1];
    if (A2 != PC_A) w_st2 = r_mem[A2];
  end

  // Operand port 1: PC, then primary-write bypass, then secondary-write bypass, then storage.
  always_comb begin
    RD1 = w_st1;
    if (A1 == PC_A) begin
      RD1 = R15;
    end else if (w_byp && WE3 && (A3 == A1)) begin
      RD1 = WD3;
    end else if (w_byp && WE5 && (A5 == A1)) begin
      RD1 = WD5;
    end
  end

  // Operand port 2: same priority as port 1.
  always_comb begin
    RD2 = w_st2;
    if (A2 == PC_A) begin
      RD2 = R15;
    end else if (w_byp && WE3 && (A3 == A2)) begin
      RD2 = WD3;
    end else if (w_byp && WE5 && (A5 == A2)) begin
      RD2 = WD5;
    end
  end

  // Debug port: stored value only, so it shows the pre-write contents during a write cycle.
  always_comb begin
    RD4 = R15;
    if (A4 != PC_A) RD4 = r_mem[A4];
  end

  // Hazard outputs: a pending load is hidden when its return is being forwarded this cycle.
  always_comb begin
    BUSY1 = 1'b0;
    BUSY2 = 1'b0;
    if (A1 != PC_A) BUSY1 = r_pend[A1] && !(w_byp && WE3 && (A3 == A1));
    if (A2 != PC_A) BUSY2 = r_pend[A2] && !(w_byp && WE3 && (A3 == A2));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance share all inputs.
// Each table row is one clock cycle: inputs applied after the edge, outputs checked at the falling edge.
module tb_regfile_mp;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  A1, A2, A4, A3, A5, AM;
  logic [31:0] R15, WD3, WD5;
  logic        WE3, WE5, MARK;

  logic [31:0] rd1, rd2, rd4;
  logic        busy1, busy2, werr;
  logic [31:0] b0_rd1, b0_rd2, b0_rd4;
  logic        b0_busy1, b0_busy2, b0_werr;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(1)) dut (
    .CLK(CLK), .RESET(RESET), .A1(A1), .A2(A2), .RD1(rd1), .RD2(rd2),
    .A4(A4), .RD4(rd4), .R15(R15), .WE3(WE3), .A3(A3), .WD3(WD3),
    .WE5(WE5), .A5(A5), .WD5(WD5), .MARK(MARK), .AM(AM),
    .BUSY1(busy1), .BUSY2(busy2), .WERR(werr)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .A1(A1), .A2(A2), .RD1(b0_rd1), .RD2(b0_rd2),
    .A4(A4), .RD4(b0_rd4), .R15(R15), .WE3(WE3), .A3(A3), .WD3(WD3),
    .WE5(WE5), .A5(A5), .WD5(WD5), .MARK(MARK), .AM(AM),
    .BUSY1(b0_busy1), .BUSY2(b0_busy2), .WERR(b0_werr)
  );

  typedef struct {
    logic        rst;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        we5;
    logic [3:0]  a5;
    logic [31:0] wd5;
    logic        mark;
    logic [3:0]  am;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  a4;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_rd4;
    logic        e_b1;
    logic        e_b2;
    logic        e_werr;
    logic [31:0] e0_rd1;
    logic        e0_b2;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [31:0] rst, we3, a3, wd3, we5, a5, wd5, mark, am, a1, a2, a4,
    input logic [31:0] rd1_e, rd2_e, rd4_e, b1_e, b2_e, werr_e, rd1_0, b2_0);
    vec_t v;
    v.rst = rst[0];   v.we3 = we3[0];  v.a3 = a3[3:0];   v.wd3 = wd3;
    v.we5 = we5[0];   v.a5 = a5[3:0];  v.wd5 = wd5;      v.mark = mark[0];
    v.am = am[3:0];   v.a1 = a1[3:0];  v.a2 = a2[3:0];   v.a4 = a4[3:0];
    v.e_rd1 = rd1_e;  v.e_rd2 = rd2_e; v.e_rd4 = rd4_e;
    v.e_b1 = b1_e[0]; v.e_b2 = b2_e[0]; v.e_werr = werr_e[0];
    v.e0_rd1 = rd1_0; v.e0_b2 = b2_0[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; WE3 = 1'b0; A3 = '0; WD3 = '0; WE5 = 1'b0; A5 = '0; WD5 = '0;
    MARK = 1'b0; AM = '0; A1 = '0; A2 = '0; A4 = '0;
  endtask

  initial begin
    //            rst we3 a3 wd3           we5 a5 wd5   mk am a1 a2 a4   rd1           rd2           rd4           b1 b2 we  b0rd1         b0b2
    tbl[0]  = mk(0, 1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 3, 0, 3,   32'hDEADBEEF, 0,            0,            0, 0, 0,  0,            0);
    tbl[1]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 3, 0, 3,   32'hDEADBEEF, 0,            32'hDEADBEEF, 0, 0, 0,  32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 7, 3, 7,  32'h11,       32'hDEADBEEF, 0,            0, 0, 0,  0,            0);
    tbl[3]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 7, 7, 7,   32'h11,       32'h11,       32'h11,       0, 0, 1,  32'h11,       0);
    tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 7, 0, 0,   32'h11,       0,            0,            0, 0, 0,  32'h11,       0);
    tbl[5]  = mk(0, 0, 0, 0,            1, 6, 32'h66, 0, 0, 6, 6, 6,  32'h66,       32'h66,       0,            0, 0, 0,  0,            0);
    tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 6, 0, 6,   32'h66,       0,            32'h66,       0, 0, 0,  32'h66,       0);
    tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0,     1, 5, 5, 5, 0,   0,            0,            0,            0, 0, 0,  0,            0);
    tbl[8]  = mk(0, 0, 0, 0,            1, 5, 32'h55, 0, 0, 5, 5, 5,  32'h55,       32'h55,       0,            1, 1, 0,  0,            1);
    tbl[9]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 5, 5, 5,   32'h55,       32'h55,       32'h55,       1, 1, 0,  32'h55,       1);
    tbl[10] = mk(0, 1, 5, 32'h5A,       0, 0, 0,     0, 0, 5, 5, 0,   32'h5A,       32'h5A,       0,            0, 0, 0,  32'h55,       1);
    tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 5, 5, 0,   32'h5A,       32'h5A,       0,            0, 0, 0,  32'h5A,       0);
    tbl[12] = mk(0, 1, 9, 32'h99,       0, 0, 0,     1, 9, 9, 0, 0,   32'h99,       0,            0,            0, 0, 0,  0,            0);
    tbl[13] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 9, 9, 0,   32'h99,       32'h99,       0,            1, 1, 0,  32'h99,       1);
    tbl[14] = mk(0, 1, 15, 32'hFFFFFFFF, 1, 15, 32'h77, 0, 0, 15, 3, 15, 32'h108,   32'hDEADBEEF, 32'h108,      0, 0, 0,  32'h108,      0);
    tbl[15] = mk(0, 0, 0, 0,            0, 0, 0,     1, 15, 15, 15, 0, 32'h108,     32'h108,      0,            0, 0, 0,  32'h108,      0);
    tbl[16] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 14, 15, 0, 0,            32'h108,      0,            0, 0, 0,  0,            0);
    tbl[17] = mk(0, 1, 2, 32'hAB,       0, 0, 0,     1, 2, 2, 0, 0,   32'hAB,       0,            0,            0, 0, 0,  0,            0);
    tbl[18] = mk(0, 0, 0, 0,            0, 0, 0,     1, 4, 2, 2, 0,   32'hAB,       32'hAB,       0,            1, 1, 0,  32'hAB,       1);
    tbl[19] = mk(1, 1, 4, 32'h44,       1, 4, 32'h55, 0, 0, 2, 4, 0,  32'hAB,       32'h44,       0,            1, 0, 0,  32'hAB,       1);
    tbl[20] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 2, 4, 2,   0,            0,            0,            0, 0, 0,  0,            0);
    tbl[21] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 4, 2, 4,   0,            0,            0,            0, 0, 0,  0,            0);

    idle_inputs();
    R15   = 32'h0000_0108;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Post-reset sweep: every stored register reads 0 with no pending loads.
    for (int a = 0; a < 15; a++) begin
      A1 = 4'(a); A2 = 4'(14 - a); A4 = 4'(a);
      #1;
      chk($sformatf("rst_rd1[%0d]", a), rd1, 32'h0);
      chk($sformatf("rst_rd2[%0d]", 14 - a), rd2, 32'h0);
      chk($sformatf("rst_rd4[%0d]", a), rd4, 32'h0);
      chk($sformatf("rst_busy[%0d]", a), {30'd0, busy1, busy2}, 32'h0);
      chk($sformatf("rst_b0_rd1[%0d]", a), b0_rd1, 32'h0);
    end
    chk("rst_werr", {30'd0, werr, b0_werr}, 32'h0);
    A1 = 4'd15; A4 = 4'd15;
    #1;
    chk("rst_rd1_pc", rd1, 32'h0000_0108);
    chk("rst_rd4_pc", rd4, 32'h0000_0108);
    chk("rst_busy1_pc", {31'd0, busy1}, 32'h0);

    @(posedge CLK);
    #1;
    for (int i = 0; i < NV; i++) begin
      RESET = tbl[i].rst;
      WE3 = tbl[i].we3; A3 = tbl[i].a3; WD3 = tbl[i].wd3;
      WE5 = tbl[i].we5; A5 = tbl[i].a5; WD5 = tbl[i].wd5;
      MARK = tbl[i].mark; AM = tbl[i].am;
      A1 = tbl[i].a1; A2 = tbl[i].a2; A4 = tbl[i].a4;
      @(negedge CLK);
      chk($sformatf("v%0d_rd1", i), rd1, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd2, tbl[i].e_rd2);
      chk($sformatf("v%0d_rd4", i), rd4, tbl[i].e_rd4);
      chk($sformatf("v%0d_busy1", i), {31'd0, busy1}, {31'd0, tbl[i].e_b1});
      chk($sformatf("v%0d_busy2", i), {31'd0, busy2}, {31'd0, tbl[i].e_b2});
      chk($sformatf("v%0d_werr", i), {31'd0, werr}, {31'd0, tbl[i].e_werr});
      chk($sformatf("v%0d_nobyp_rd1", i), b0_rd1, tbl[i].e0_rd1);
      chk($sformatf("v%0d_nobyp_busy2", i), {31'd0, b0_busy2}, {31'd0, tbl[i].e0_b2});
      @(posedge CLK);
      #1;
    end

    // Mid-stream reset must have cleared every stored word in both instances.
    idle_inputs();
    for (int a = 0; a < 15; a++) begin
      A4 = 4'(a);
      #1;
      chk($sformatf("mid_rst_rd4[%0d]", a), rd4, 32'h0);
      chk($sformatf("mid_rst_b0_rd4[%0d]", a), b0_rd4, 32'h0);
    end
    chk("mid_rst_werr", {30'd0, werr, b0_werr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised successor to the core's single-write register file. Adds a second write port for base-register writeback, write-to-read bypass, synchronous clear and a per-register pending-load scoreboard. It sits in the decode/writeback boundary of the pipelined core. Read ports feed operand fetch, and the scoreboard drives the hazard unit's stall decision.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; architectural registers 0..2**ADDR_W-1
- PC_IDX, 15, index sourced from the R15 input, not stored; must equal 2**ADDR_W-1
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
- CLK  in  1  single clock, all state updates on posedge
- RESET  in  1  synchronous, active-high
- A1, A2  in  ADDR_W  operand read addresses
- RD1, RD2  out  DATA_W  operand read data (combinational)
- A4  in  ADDR_W  debug read address
- RD4  out  DATA_W  debug read data (stored value, never bypassed)
- R15  in  DATA_W  PC+8 value returned for reads of PC_IDX
- WE3  in  1  primary write enable (ALU result / load return)
- A3  in  ADDR_W  primary write address
- WD3  in  DATA_W  primary write data
- WE5  in  1  secondary write enable (base writeback)
- A5  in  ADDR_W  secondary write address
- WD5  in  DATA_W  secondary write data
- MARK  in  1  issue of a load: set pending bit of AM
- AM  in  ADDR_W  load destination address
- BUSY1, BUSY2  out  1  operand at A1/A2 has a load pending
- WERR  out  1  registered pulse: write-port collision seen last cycle

## Operation
- Storage: 2**ADDR_W-1 words (indices 0..PC_IDX-1), plus a pending vector of the same length.
- Writes at posedge:
  - WE3 stores WD3 at A3 and WE5 stores WD5 at A5.
  - A write to PC_IDX is discarded (the PC is owned elsewhere).
- Collision: WE3 & WE5 & A3==A5 (not PC_IDX):
  - WD3 is stored and WD5 is dropped.
  - WERR=1 for exactly the following cycle.
- Reads, for n in {1,2}:
  - An==PC_IDX gives R15.
  - Otherwise, if BYPASS and WE3 & A3==An, the result is WD3.
  - Otherwise, if BYPASS and WE5 & A5==An, the result is WD5.
  - Otherwise the result is the stored value.
  - WE3 has priority over WE5, matching the collision rule.
- RD4: the stored value at A4; A4==PC_IDX gives R15.
- Scoreboard:
  - MARK sets pending[AM]. A WE3 write clears pending[A3]; WE5 never clears it.
  - MARK & WE3 & AM==A3 in the same cycle: the bit ends set (the new load wins).
  - MARK to PC_IDX is ignored.
- BUSYn = pending[An] & ~(BYPASS & WE3 & A3==An). BUSYn is 0 for An==PC_IDX.
- Reset (RESET=1 at posedge):
  - All stored registers go to 0, all pending bits to 0, and WERR to 0.
  - Writes and MARK in the reset cycle are ignored.

## Timing
- Write-to-storage latency is 1 cycle. With BYPASS=1, read-after-write costs 0 cycles (same-cycle forwarding). With BYPASS=0 it costs 1 cycle.
- RD1, RD2, RD4, BUSY1 and BUSY2 are purely combinational from the current inputs and state. There is no registered output except WERR.
- After reset, every read returns 0 (PC_IDX reads return R15), and BUSY1, BUSY2 and WERR are all 0.
- MARK takes effect from the next cycle: BUSYn rises the cycle after MARK is sampled.
- RESET asserted mid-stream (pending bits set, writes active) takes priority over every other input in that cycle.

## Test plan
- Reset, then A1=0..14 and A4=0..14 -> RD1=0, RD4=0, BUSY1=0. A1=15 with R15=0x00000108 -> RD1=0x00000108.
- Write WE3, A3=3, WD3=0xDEADBEEF with A1=3 in the same cycle, BYPASS=1 -> RD1=0xDEADBEEF that cycle. RD4 (A4=3) shows the old value 0 until the next cycle, then 0xDEADBEEF. Repeat with BYPASS=0 -> RD1 stays 0 until the next cycle.
- WE3 and WE5 both to A=7, WD3=0x11, WD5=0x22 -> RD1 (A1=7) = 0x11 in the same cycle. R7=0x11 after the edge. WERR=1 for one cycle, then 0.
- MARK, AM=5; next cycle A2=5 -> BUSY2=1. Then WE5 to 5 -> BUSY2 stays 1. Then WE3, A3=5 -> BUSY2=0 in that cycle (BYPASS=1) and pending cleared afterwards.
- MARK, AM=9 together with WE3, A3=9 -> pending[9]=1 next cycle. WE3, A3=15, WD3=0xFFFFFFFF -> no stored register changes and RD1 (A1=15) = R15.
- Set pending on 2, 4 and write R2=0xAB, then assert RESET together with WE3 to 4 -> next cycle R2=0, R4=0, BUSY for 2 and 4 = 0, WERR=0.
